// File: rtl/mj_reset_seq.sv
// ---------------------------------------------------------------------------
// mj_reset_seq -- reset sequencer for the picoJava-II core.
//
// Releases the I/O, cache and core reset domains in a fixed order:
//   ASSERT -> WAIT_LOCK -> IO_REL -> CACHE_INIT -> RUN
// There is a hold period between stages. Before the core leaves reset, the
// sequencer waits for the cache controllers to finish their invalidate sweep
// or for a timeout to expire. A soft reset request from RUN passes through
// SOFT and then re-runs the cache invalidate. I/O stays out of reset during
// that warm reset.
//
// Ports:
//   clk              core clock, rising edge
//   reset            synchronous active-high board reset
//   pll_lock         PLL locked (already synchronous to clk)
//   soft_rst_req     level request for a core+cache warm reset
//   cache_init_done  invalidate sweep complete (pulse or level)
//   io_reset_l       active-low reset, bus interface unit
//   cache_reset_l    active-low reset, I$/D$ controllers
//   core_reset_l     active-low reset, IU/SMU/FPU/spare cells
//   cache_init_start one-cycle pulse on the first cycle of CACHE_INIT
//   rst_state        current FSM state code (debug/scan)
//   rst_timeout      sticky flag, set when the cache init timed out
// ---------------------------------------------------------------------------
module mj_reset_seq #(
  parameter int HOLD_CYC       = 16,
  parameter int CACHE_INIT_TMO = 1024,
  parameter int CNT_W          = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  input  logic       cache_init_done,
  output logic       io_reset_l,
  output logic       cache_reset_l,
  output logic       core_reset_l,
  output logic       cache_init_start,
  output logic [2:0] rst_state,
  output logic       rst_timeout
);

  typedef enum logic [2:0] {
    ST_ASSERT     = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_IO_REL     = 3'd2,
    ST_CACHE_INIT = 3'd3,
    ST_RUN        = 3'd4,
    ST_SOFT       = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(CACHE_INIT_TMO - 1);

  // Release masks indexed by state code: bit n set means that domain is out
  // of reset in state n. Codes 6/7 keep every domain in reset.
  // Entry 0 = io, 1 = cache, 2 = core.
  localparam logic [7:0] REL_TABLE [3] = '{
    8'b0011_1100,
    8'b0001_1000,
    8'b0001_0000
  };

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;
  logic             start_reg, start_next;
  logic [2:0]       rel_reg, rel_next;

  // Next-state logic. Loss of PLL lock overrides everything except reset in
  // every state that has released a domain.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CNT_W'(1);
    timeout_next = timeout_reg;
    start_next   = 1'b0;
    case (state_reg)
      ST_ASSERT: begin
        if (cnt_reg == HOLD_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (pll_lock) state_next = ST_IO_REL;
      end
      ST_IO_REL, ST_SOFT: begin
        if (!pll_lock) begin
          state_next = ST_ASSERT;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = ST_CACHE_INIT;
          start_next = 1'b1;
        end
      end
      ST_CACHE_INIT: begin
        if (!pll_lock) begin
          state_next = ST_ASSERT;
        end else if (cache_init_done) begin
          // done wins over a coincident timeout
          state_next = ST_RUN;
        end else if (cnt_reg == TMO_LAST) begin
          state_next   = ST_RUN;
          timeout_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (!pll_lock)         state_next = ST_ASSERT;
        else if (soft_rst_req) state_next = ST_SOFT;
      end
      default: state_next = ST_ASSERT;
    endcase
    if (state_next != state_reg) cnt_next = '0;
  end

  // The reset_l outputs are flopped from the next state rather than decoded
  // from the multi-bit state register, so they cannot glitch.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rel
      assign rel_next[gi] = REL_TABLE[gi][state_next];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_ASSERT;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
      start_reg   <= 1'b0;
      rel_reg     <= 3'b000;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
      start_reg   <= start_next;
      rel_reg     <= rel_next;
    end
  end

  assign io_reset_l       = rel_reg[0];
  assign cache_reset_l    = rel_reg[1];
  assign core_reset_l     = rel_reg[2];
  assign cache_init_start = start_reg;
  assign rst_state        = state_reg;
  assign rst_timeout      = timeout_reg;

endmodule

// File: tb/tb_mj_reset_seq.sv
module tb_mj_reset_seq;
  localparam int HOLD = 16;
  localparam int TMO  = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       cache_init_done = 1'b0;
  logic       io_reset_l, cache_reset_l, core_reset_l, cache_init_start;
  logic [2:0] rst_state;
  logic       rst_timeout;

  int checks = 0;
  int failures = 0;

  // Reference model: spec state code plus a countdown of cycles left in the
  // current timed phase.
  int m_state = 0;
  int m_left  = HOLD;
  bit m_to    = 1'b0;
  bit m_start = 1'b0;

  always #5 clk = ~clk;

  mj_reset_seq #(.HOLD_CYC(HOLD), .CACHE_INIT_TMO(TMO), .CNT_W(12)) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .soft_rst_req(soft_rst_req),
    .cache_init_done(cache_init_done), .io_reset_l(io_reset_l),
    .cache_reset_l(cache_reset_l), .core_reset_l(core_reset_l),
    .cache_init_start(cache_init_start), .rst_state(rst_state),
    .rst_timeout(rst_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_start = 1'b0;
    if (reset) begin
      m_state = 0; m_left = HOLD; m_to = 1'b0;
    end else if (m_state >= 2 && !pll_lock) begin
      m_state = 0; m_left = HOLD;
    end else begin
      case (m_state)
        0: begin m_left--; if (m_left == 0) m_state = 1; end
        1: if (pll_lock) begin m_state = 2; m_left = HOLD; end
        2, 5: begin
          m_left--;
          if (m_left == 0) begin m_state = 3; m_left = TMO; m_start = 1'b1; end
        end
        3: begin
          if (cache_init_done) m_state = 4;
          else begin
            m_left--;
            if (m_left == 0) begin m_state = 4; m_to = 1'b1; end
          end
        end
        4: if (soft_rst_req) begin m_state = 5; m_left = HOLD; end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("rst_state", 32'(rst_state), 32'(m_state));
    chk("io_reset_l", 32'(io_reset_l), 32'(m_state >= 2));
    chk("cache_reset_l", 32'(cache_reset_l), 32'(m_state == 3 || m_state == 4));
    chk("core_reset_l", 32'(core_reset_l), 32'(m_state == 4));
    chk("cache_init_start", 32'(cache_init_start), 32'(m_start));
    chk("rst_timeout", 32'(rst_timeout), 32'(m_to));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int n;

  initial begin
    // 1: defaults, done 7 cycles after start
    reset = 1'b1; pll_lock = 1'b1;
    run(3);
    chk("reset_state", 32'(rst_state), 32'd0);
    chk("reset_io", 32'(io_reset_l), 32'd0);
    reset = 1'b0;
    n = 0;
    do begin tick(); n++; end while (io_reset_l !== 1'b1 && n < 100);
    chk("io_rel_edge", 32'(n), 32'd17);
    do begin tick(); n++; end while (cache_init_start !== 1'b1 && n < 100);
    chk("cache_start_edge", 32'(n), 32'd33);
    chk("cache_rel_at_start", 32'(cache_reset_l), 32'd1);
    run(6);
    cache_init_done = 1'b1; tick(); cache_init_done = 1'b0;
    chk("core_rel_after_done", 32'(core_reset_l), 32'd1);
    chk("no_timeout", 32'(rst_timeout), 32'd0);

    // 2: PLL lock held low
    reset = 1'b1; tick(); reset = 1'b0; pll_lock = 1'b0;
    run(HOLD + 50);
    chk("wait_lock_state", 32'(rst_state), 32'd1);
    chk("wait_lock_io", 32'(io_reset_l), 32'd0);
    pll_lock = 1'b1; tick();
    chk("lock_to_io_rel", 32'(rst_state), 32'd2);

    // 3: cache init never completes
    n = 0;
    do begin tick(); n++; end while (cache_init_start !== 1'b1 && n < 40);
    n = 0;
    do begin tick(); n++; end while (core_reset_l !== 1'b1 && n < 1100);
    chk("timeout_cycles", 32'(n), 32'(TMO));
    chk("timeout_set", 32'(rst_timeout), 32'd1);

    // 4: one-cycle soft reset
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    chk("soft_core", 32'(core_reset_l), 32'd0);
    chk("soft_cache", 32'(cache_reset_l), 32'd0);
    chk("soft_io", 32'(io_reset_l), 32'd1);
    n = 0;
    do begin tick(); n++; end while (cache_init_start !== 1'b1 && n < 40);
    chk("soft_hold_cycles", 32'(n), 32'(HOLD));
    cache_init_done = 1'b1; tick(); cache_init_done = 1'b0;
    chk("soft_done_core", 32'(core_reset_l), 32'd1);
    chk("timeout_sticky", 32'(rst_timeout), 32'd1);

    // 5: lock loss coincident with done
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    n = 0;
    do begin tick(); n++; end while (cache_init_start !== 1'b1 && n < 40);
    run(2);
    pll_lock = 1'b0; cache_init_done = 1'b1; tick();
    pll_lock = 1'b1; cache_init_done = 1'b0;
    chk("lock_loss_state", 32'(rst_state), 32'd0);
    chk("lock_loss_io", 32'(io_reset_l), 32'd0);

    // 6a: done coincident with the timeout count
    reset = 1'b1; tick(); reset = 1'b0;
    n = 0;
    do begin tick(); n++; end while (cache_init_start !== 1'b1 && n < 60);
    run(TMO - 1);
    cache_init_done = 1'b1; tick(); cache_init_done = 1'b0;
    chk("done_vs_tmo_state", 32'(rst_state), 32'd4);
    chk("done_vs_tmo_flag", 32'(rst_timeout), 32'd0);

    // 6b: reset in the middle of IO_REL
    reset = 1'b1; tick(); reset = 1'b0;
    run(HOLD + 1 + 5);
    chk("mid_io_rel", 32'(rst_state), 32'd2);
    reset = 1'b1; tick();
    chk("mid_reset_state", 32'(rst_state), 32'd0);
    chk("mid_reset_io", 32'(io_reset_l), 32'd0);
    reset = 1'b0;

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 399) == 0);
      pll_lock        = ($urandom_range(0, 299) != 0);
      soft_rst_req    = ($urandom_range(0, 59) == 0);
      cache_init_done = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mj_reset_seq.md
Name: mj_reset_seq

Overview:
- Reset sequencer for the picoJava-II core; sits directly upstream of every core unit, including the spare-cell block, and drives their active-low `reset_l` inputs.
- Takes one board-level synchronous reset, PLL lock and a software reset request.
- Releases the I/O, cache and core reset domains in a fixed order, with hold counts between stages.
- Handshakes with the cache controllers so the core leaves reset only after cache invalidation completes, or a timeout expires.

Parameters:
- HOLD_CYC, 16, cycles each hold stage lasts (ASSERT, IO_REL, SOFT); legal range 1 to 2^CNT_W-1.
- CACHE_INIT_TMO, 1024, maximum cycles spent waiting for cache_init_done.
- CNT_W, 12, width of the shared stage counter; must represent max(HOLD_CYC, CACHE_INIT_TMO).

Ports:
- clk  input  1  core clock; all logic on rising edge.
- reset  input  1  synchronous, active-high board reset.
- pll_lock  input  1  PLL locked, already synchronous to clk.
- soft_rst_req  input  1  level request for a core+cache warm reset, from the trap/SU logic.
- cache_init_done  input  1  pulse or level from the I$/D$ controllers: invalidate sweep complete.
- io_reset_l  output  1  active-low reset to the bus interface unit.
- cache_reset_l  output  1  active-low reset to the I$/D$ controllers.
- core_reset_l  output  1  active-low reset to the IU, SMU, FPU and spare cells.
- cache_init_start  output  1  one-cycle pulse that starts the cache invalidate sweep.
- rst_state  output  3  current FSM state, for debug and scan observation.
- rst_timeout  output  1  sticky flag: cache init timed out.

Behaviour:
- Single clock domain.
- reset is synchronous and active-high; it is sampled only at the rising edge of clk.

Reset values (while reset=1):
- State ASSERT, counter 0.
- io_reset_l=0, cache_reset_l=0, core_reset_l=0.
- cache_init_start=0, rst_timeout=0, rst_state=0.

Output timing:
- All outputs are registered: either decodes of the state register or flops.
- There is no combinational path from any input to any output.

State encoding and outputs (io/cache/core reset_l):
- ASSERT=0: 0/0/0.
- WAIT_LOCK=1: 0/0/0.
- IO_REL=2: 1/0/0.
- CACHE_INIT=3: 1/1/0.
- RUN=4: 1/1/1.
- SOFT=5: 1/0/0.
- Codes 6 and 7 are illegal and go to ASSERT on the next edge.

Transitions (the counter clears on every state change):
- ASSERT: counter increments each cycle. When counter==HOLD_CYC-1, go to WAIT_LOCK. ASSERT therefore occupies HOLD_CYC cycles.
- WAIT_LOCK: stay until pll_lock=1, then go to IO_REL. Minimum occupancy is 1 cycle.
- IO_REL: hold for HOLD_CYC cycles, then go to CACHE_INIT. cache_init_start=1 for exactly the first cycle of CACHE_INIT.
- CACHE_INIT: counter increments each cycle.
  - cache_init_done=1 → RUN.
  - Otherwise, when counter==CACHE_INIT_TMO-1 → RUN and set rst_timeout=1.
  - If done and the timeout occur in the same cycle, done wins and rst_timeout is not set.
- RUN: soft_rst_req=1 → SOFT. Otherwise stay.
- SOFT: hold for HOLD_CYC cycles, then go to CACHE_INIT, which pulses cache_init_start again. io_reset_l stays 1 throughout.

Priorities:
- reset > pll_lock loss > all other conditions.
- In any state other than ASSERT and WAIT_LOCK, pll_lock=0 → ASSERT on the next edge. All three reset_l outputs drop in that cycle and the counter restarts.
- pll_lock loss in the same cycle as soft_rst_req or cache_init_done → ASSERT.
- soft_rst_req is ignored outside RUN; no queuing.
- A request held high across SOFT re-enters SOFT immediately after RUN is reached.
- cache_init_done outside CACHE_INIT is ignored.

rst_timeout:
- Cleared only by reset.
- Persists across pll_lock loss and soft reset.

Reset mid-operation:
- Any state → ASSERT on the next edge, with all outputs at their reset values that cycle.

Test Plan:
1. Defaults; reset=1 for 3 cycles, pll_lock=1, done pulse 7 cycles after cache_init_start → io_reset_l rises at edge 17 after reset release; cache_reset_l rises and cache_init_start pulses at edge 33; core_reset_l rises the edge after done; rst_timeout=0.
2. pll_lock held 0 for 50 cycles after ASSERT → state stays WAIT_LOCK (rst_state=1) with all reset_l=0; the sequence proceeds 1 cycle after lock rises.
3. cache_init_done never asserted → RUN reached 1024 cycles after cache_init_start; rst_timeout=1 and stays 1 through a later soft reset.
4. In RUN, assert soft_rst_req for 1 cycle → core_reset_l and cache_reset_l drop next edge, io_reset_l stays 1; 16 cycles later cache_init_start pulses; on done, core_reset_l=1.
5. In CACHE_INIT, drop pll_lock in the same cycle as cache_init_done → ASSERT next edge, all reset_l=0, rst_state=0.
6. Done coincident with the timeout count; reset asserted mid-IO_REL; force state code 6 → RUN with rst_timeout=0; all outputs at reset values next edge; ASSERT next edge respectively.
